// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, Control_unit and ID/EX pipeline register
// Ports: clk, rst (async active-low); IF side in_valid/in_ready/Instruction/in_pc;
// hazard_detected, flush; WB write port WB_Write_Enable/WB_Dest/WB_Data;
// EXE side out_valid/out_ready plus registered out_pc, Dest, Src1, Src2, Val1, Val2, Reg2,
// EXE_CMD, Br_type, MEM_R_EN, MEM_W_EN, WB_EN, is_imm, if_store_bne, single_src.
// Optional feature: define ID_WB_BYPASS_EN for same-cycle write-through of WB_Data to reads.
module Control_unit (
    input  logic [5:0] opcode,
    input  logic       hazard_detected,
    output logic [3:0] EXE_CMD,
    output logic [1:0] Br_type,
    output logic       MEM_R_EN,
    output logic       MEM_W_EN,
    output logic       WB_EN,
    output logic       is_imm,
    output logic       if_store_bne,
    output logic       single_src
);
    always_comb begin
        EXE_CMD      = 4'b0000;
        Br_type      = 2'b00;
        MEM_R_EN     = 1'b0;
        MEM_W_EN     = 1'b0;
        WB_EN        = 1'b0;
        is_imm       = 1'b0;
        if_store_bne = 1'b0;
        single_src   = 1'b0;
        case (opcode)
            6'b000000: begin EXE_CMD = 4'b0001; WB_EN = 1'b1; end
            6'b000001: begin EXE_CMD = 4'b0011; WB_EN = 1'b1; end
            6'b001000: begin EXE_CMD = 4'b0001; WB_EN = 1'b1; is_imm = 1'b1; single_src = 1'b1; end
            6'b100011: begin EXE_CMD = 4'b0001; MEM_R_EN = 1'b1; WB_EN = 1'b1; is_imm = 1'b1; single_src = 1'b1; end
            6'b101011: begin EXE_CMD = 4'b0001; MEM_W_EN = 1'b1; is_imm = 1'b1; if_store_bne = 1'b1; end
            6'b000100: begin Br_type = 2'b01; is_imm = 1'b1; end
            6'b000101: begin Br_type = 2'b10; is_imm = 1'b1; if_store_bne = 1'b1; end
            6'b000010: begin Br_type = 2'b11; is_imm = 1'b1; single_src = 1'b1; end
            default: ;
        endcase
        if (hazard_detected) begin
            EXE_CMD  = 4'b0000;
            Br_type  = 2'b00;
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
            WB_EN    = 1'b0;
        end
    end
endmodule

module id_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           Instruction,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  hazard_detected,
    input  logic                  flush,
    input  logic                  WB_Write_Enable,
    input  logic [REG_ADDR_W-1:0] WB_Dest,
    input  logic [DATA_W-1:0]     WB_Data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] Dest,
    output logic [REG_ADDR_W-1:0] Src1,
    output logic [REG_ADDR_W-1:0] Src2,
    output logic [DATA_W-1:0]     Val1,
    output logic [DATA_W-1:0]     Val2,
    output logic [DATA_W-1:0]     Reg2,
    output logic [3:0]            EXE_CMD,
    output logic [1:0]            Br_type,
    output logic                  MEM_R_EN,
    output logic                  MEM_W_EN,
    output logic                  WB_EN,
    output logic                  is_imm,
    output logic                  if_store_bne,
    output logic                  single_src
);
    localparam int N = 2 ** REG_ADDR_W;
    logic [DATA_W-1:0]     rf [N];
    logic [REG_ADDR_W-1:0] rs, rt, rd, d_src2, d_dest;
    logic [DATA_W-1:0]     d_val1, d_reg2, d_val2, sext;
    logic [3:0]            d_cmd;
    logic [1:0]            d_br;
    logic                  d_mr, d_mw, d_wb, d_imm, d_sb, d_ss;
    logic                  hit_rs, hit_rt, free, acc;

    Control_unit cu (
        .opcode(Instruction[31:26]), .hazard_detected(1'b0), .EXE_CMD(d_cmd), .Br_type(d_br),
        .MEM_R_EN(d_mr), .MEM_W_EN(d_mw), .WB_EN(d_wb), .is_imm(d_imm),
        .if_store_bne(d_sb), .single_src(d_ss)
    );

    assign rs = Instruction[21 +: REG_ADDR_W];
    assign rt = Instruction[16 +: REG_ADDR_W];
    assign rd = Instruction[11 +: REG_ADDR_W];
`ifdef ID_WB_BYPASS_EN
    assign hit_rs = WB_Write_Enable && WB_Dest != '0 && WB_Dest == rs;
    assign hit_rt = WB_Write_Enable && WB_Dest != '0 && WB_Dest == rt;
`else
    assign hit_rs = 1'b0;
    assign hit_rt = 1'b0;
`endif
    assign sext   = {{(DATA_W-IMM_W){Instruction[IMM_W-1]}}, Instruction[IMM_W-1:0]};
    assign d_val1 = rs == '0 ? '0 : hit_rs ? WB_Data : rf[rs];
    assign d_reg2 = rt == '0 ? '0 : hit_rt ? WB_Data : rf[rt];
    assign d_val2 = d_imm ? sext : d_reg2;
    assign d_src2 = d_ss ? '0 : rt;
    assign d_dest = d_imm ? rt : rd;
    assign free     = !out_valid || out_ready;
    assign in_ready = free && !hazard_detected && !flush;
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) rf[i] <= '0;
        end else if (WB_Write_Enable && WB_Dest != '0) begin
            rf[WB_Dest] <= WB_Data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0; out_pc <= '0; Dest <= '0; Src1 <= '0; Src2 <= '0;
            Val1 <= '0; Val2 <= '0; Reg2 <= '0; EXE_CMD <= '0; Br_type <= '0;
            MEM_R_EN <= 1'b0; MEM_W_EN <= 1'b0; WB_EN <= 1'b0;
            is_imm <= 1'b0; if_store_bne <= 1'b0; single_src <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1; out_pc <= in_pc; Dest <= d_dest; Src1 <= rs; Src2 <= d_src2;
            Val1 <= d_val1; Val2 <= d_val2; Reg2 <= d_reg2; EXE_CMD <= d_cmd; Br_type <= d_br;
            MEM_R_EN <= d_mr; MEM_W_EN <= d_mw; WB_EN <= d_wb;
            is_imm <= d_imm; if_store_bne <= d_sb; single_src <= d_ss;
        end else if (flush || free) begin
            // bubble: only the side-effecting controls need clearing
            out_valid <= 1'b0; MEM_R_EN <= 1'b0; MEM_W_EN <= 1'b0; WB_EN <= 1'b0; Br_type <= '0;
        end
    end
endmodule
